pipelined_pe: RTL and testbench
===============================

// Module: pipelined_pe
// PURPOSE
//   Next-generation weight-stationary processing element for the systolic MAC array.
//   Generalises the single-weight, combinational PE:
//   - parametrised data and partial-sum widths
//   - signed/unsigned mode
//   - double-buffered weights, so a new weight loads while the current one computes
//   - registered (pipelined) psum/activation outputs with valid flags
//   - sticky overflow flag
//   One instance per array cell; activations flow right, psums flow down.
// PARAMETERS
//   DATA_W   8    activation/weight width
//   PSUM_W   20   partial-sum width; must be >= 2*DATA_W (elaboration error otherwise)
// PORTS
//   CLK           in   1        clock, rising edge
//   RST           in   1        asynchronous active-low reset
//   mode_signed   in   1        1: operands/psum two's complement; 0: unsigned
//   in_valid      in   1        in_data/psum_in valid this cycle
//   in_data       in   DATA_W   activation from left neighbour
//   psum_in       in   PSUM_W   partial sum from upper neighbour
//   w_in          in   DATA_W   weight to shadow register
//   w_load        in   1        write w_in into shadow register
//   w_swap        in   1        commit shadow weight to active weight
//   ovf_clr       in   1        clear sticky overflow flag
//   right_data    out  DATA_W   registered in_data to right neighbour
//   right_valid   out  1        registered in_valid
//   w_down        out  DATA_W   shadow weight (weight-load chain down the column)
//   psum_out      out  PSUM_W   registered psum_in + in_data*w_active
//   psum_valid    out  1        psum_out valid
//   shadow_full   out  1        shadow holds an uncommitted weight
//   ovf           out  1        sticky: an add overflowed/saturated since last clear
// BEHAVIOUR
//   - Reset (async, any time, incl. mid-stream): all registers cleared.
//     Outputs are 0; shadow_full=0; w_active=0; any in-flight result is discarded.
//   - Datapath latency: 1 cycle. Cycle k with in_valid=1 gives, at cycle k+1:
//     psum_valid=1, right_valid=1, right_data=in_data, and
//     psum_out = ext(in_data*w_active) + psum_in, using w_active as it stood in cycle k.
//   - in_valid=0: psum_valid/right_valid go 0 next cycle.
//     psum_out/right_data hold their previous values (no toggle).
//   - Product: 2*DATA_W bits; sign-extended (signed) or zero-extended (unsigned) to PSUM_W.
//     mode_signed is sampled in the same cycle as the operands.
//   - Add: modulo 2^PSUM_W (wrap).
//     Overflow = signed overflow (mode_signed=1) or carry-out (mode_signed=0).
//     Overflow sets ovf next cycle. ovf_clr clears ovf; a simultaneous set wins over the clear.
//   - Weight buffer, 2 states:
//     EMPTY (shadow_full=0), FULL (shadow_full=1).
//     EMPTY --w_load--> FULL
//     FULL --w_swap--> EMPTY (w_active <= shadow)
//     FULL --w_load--> FULL (shadow overwritten)
//     FULL --w_swap & w_load--> FULL (w_active <= old shadow; shadow <= w_in)
//     EMPTY --w_swap--> ignored (w_active unchanged)
//   - A swap in a cycle with in_valid=1 does not affect that cycle's product.
//     The new weight applies from the next cycle.
// CONFIGURATION
//   PE_SAT_EN defined:
//     - The add saturates to the mode's PSUM_W range instead of wrapping:
//       signed  [-2^(PSUM_W-1), 2^(PSUM_W-1)-1]
//       unsigned [0, 2^PSUM_W-1]
//     - ovf is set on every saturation.
//   PE_SAT_EN undefined: wrap arithmetic; ovf still reports overflow.
// STRUCTURE
//   - Package pe_pkg:
//     DATA_W/PSUM_W defaults
//     weight-buffer state typedef (W_EMPTY, W_FULL)
//     functions sat_max(width,signed) and sat_min(width,signed)
//   - Sub-module pe_mult: combinational signed/unsigned DATA_W x DATA_W -> 2*DATA_W multiplier.
//     Reused by the array's bias/scale units.
// TESTING
//   1. Reset; w_load w_in=3, w_swap; in_valid in_data=5 psum_in=10
//      -> next cycle psum_out=25, psum_valid=1, right_data=5.
//   2. Signed: w=-2 (8'hFE), in_data=7, psum_in=4 -> psum_out=-10 (20'hFFFF6).
//      Same operands unsigned -> 254*7+4=1782.
//   3. Double buffer: active=3, load shadow=4 while streaming in_data=1,2;
//      swap with in_data=2 valid -> results 3,6, then next in_data=2 -> 8.
//      Swap when EMPTY -> weight unchanged.
//   4. Overflow: unsigned, psum_in=20'hFFFFF, product 1
//      -> wrap gives 0 with ovf=1 (PE_SAT_EN: 20'hFFFFF, ovf=1).
//      ovf_clr -> 0.
//   5. Reset asserted mid-stream with psum_valid=1
//      -> outputs 0, shadow_full=0, w_active=0 immediately.
//   6. in_valid gaps (1,0,1)
//      -> psum_valid 1,0,1 one cycle later; psum_out holds through the gap.

Source files
------------

// File: rtl/pipelined_pe_pkg.sv
// pe_pkg: shared defaults, weight-buffer state type and saturation bounds for pipelined_pe
package pe_pkg;
  localparam int PE_DATA_W = 8;
  localparam int PE_PSUM_W = 20;
  typedef enum logic {W_EMPTY, W_FULL} wbuf_state_e;
  function automatic logic [63:0] sat_max(int width, logic is_signed);
    return is_signed ? (64'd1 << (width - 1)) - 64'd1 : (64'd1 << width) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(int width, logic is_signed);
    return is_signed ? ~64'd0 << (width - 1) : 64'd0;
  endfunction
endpackage

// File: rtl/pipelined_pe_if.sv
// pipelined_pe_if: operand, weight-load and result bundle of one PE cell
//   master drives mode_signed/in_valid/in_data/psum_in/w_in/w_load/w_swap/ovf_clr
//   slave (the PE) drives right_data/right_valid/w_down/psum_out/psum_valid/shadow_full/ovf
interface pipelined_pe_if #(parameter int DATA_W = 8, parameter int PSUM_W = 20);
  logic              mode_signed;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [PSUM_W-1:0] psum_in;
  logic [DATA_W-1:0] w_in;
  logic              w_load;
  logic              w_swap;
  logic              ovf_clr;
  logic [DATA_W-1:0] right_data;
  logic              right_valid;
  logic [DATA_W-1:0] w_down;
  logic [PSUM_W-1:0] psum_out;
  logic              psum_valid;
  logic              shadow_full;
  logic              ovf;
  modport master (
    output mode_signed, in_valid, in_data, psum_in, w_in, w_load, w_swap, ovf_clr,
    input  right_data, right_valid, w_down, psum_out, psum_valid, shadow_full, ovf
  );
  modport slave (
    input  mode_signed, in_valid, in_data, psum_in, w_in, w_load, w_swap, ovf_clr,
    output right_data, right_valid, w_down, psum_out, psum_valid, shadow_full, ovf
  );
endinterface

// File: rtl/pipelined_pe_mult.sv
// pe_mult: combinational signed/unsigned DATA_W x DATA_W -> 2*DATA_W multiplier
//   a, b: operands; mode_signed: 1 two's complement, 0 unsigned; p: full-width product
module pe_mult #(parameter int DATA_W = 8) (
  input  logic                  mode_signed,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   p
);
  logic signed [DATA_W:0]     a_s, b_s;
  logic signed [2*DATA_W-1:0] a_x, b_x;
  // One extra sign bit lets a single signed multiply serve both modes; the
  // product is exact modulo 2^(2*DATA_W), which covers either interpretation.
  always_comb begin
    a_s = {mode_signed & a[DATA_W-1], a};
    b_s = {mode_signed & b[DATA_W-1], b};
    a_x = (2*DATA_W)'(a_s);
    b_x = (2*DATA_W)'(b_s);
    p   = a_x * b_x;
  end
endmodule

// File: rtl/pipelined_pe.sv
// pipelined_pe: weight-stationary MAC cell with double-buffered weight and registered outputs
//   CLK: rising-edge clock; RST: asynchronous active-low reset
//   bus (pipelined_pe_if.slave): operands/weight control in, psum/activation/status out
//   PE_SAT_EN defined: the psum add saturates to the mode's range instead of wrapping
module pipelined_pe import pe_pkg::*; #(
  parameter int DATA_W = PE_DATA_W,
  parameter int PSUM_W = PE_PSUM_W
) (
  input logic          CLK,
  input logic          RST,
  pipelined_pe_if.slave bus
);
  if (PSUM_W < 2*DATA_W) begin : g_width_chk
    $error("pipelined_pe: PSUM_W must be >= 2*DATA_W");
  end
  wbuf_state_e             state_q, state_d;
  logic [DATA_W-1:0]       shadow_q, shadow_d, w_active_q, w_active_d, data_q, data_d;
  logic [PSUM_W-1:0]       psum_q, psum_d, prod_ext, add_res;
  logic                    valid_q, valid_d, ovf_q, ovf_d, add_ovf;
  logic [2*DATA_W-1:0]     prod;
  logic signed [2*DATA_W:0] prod_s;
  logic [PSUM_W:0]         sum;
  pe_mult #(.DATA_W(DATA_W)) u_mult (
    .mode_signed(bus.mode_signed),
    .a          (bus.in_data),
    .b          (w_active_q),
    .p          (prod)
  );
  always_comb begin
    state_d    = (state_q == W_FULL && bus.w_swap && !bus.w_load) ? W_EMPTY :
                 bus.w_load ? W_FULL : state_q;
    w_active_d = (state_q == W_FULL && bus.w_swap) ? shadow_q : w_active_q;
    shadow_d   = bus.w_load ? bus.w_in : shadow_q;
  end
  always_comb begin
    prod_s   = {bus.mode_signed & prod[2*DATA_W-1], prod};
    prod_ext = PSUM_W'(prod_s);
    sum      = {1'b0, prod_ext} + {1'b0, bus.psum_in};
    // Signed overflow: both addends share a sign the result does not.
    add_ovf  = bus.mode_signed ?
               (prod_ext[PSUM_W-1] == bus.psum_in[PSUM_W-1]) && (sum[PSUM_W-1] != prod_ext[PSUM_W-1]) :
               sum[PSUM_W];
`ifdef PE_SAT_EN
    add_res  = !add_ovf ? sum[PSUM_W-1:0] :
               !bus.mode_signed ? PSUM_W'(sat_max(PSUM_W, 1'b0)) :
               prod_ext[PSUM_W-1] ? PSUM_W'(sat_min(PSUM_W, 1'b1)) : PSUM_W'(sat_max(PSUM_W, 1'b1));
`else
    add_res  = sum[PSUM_W-1:0];
`endif
    psum_d   = bus.in_valid ? add_res : psum_q;
    data_d   = bus.in_valid ? bus.in_data : data_q;
    valid_d  = bus.in_valid;
    // A new overflow event wins over a same-cycle clear.
    ovf_d    = (bus.in_valid && add_ovf) || (ovf_q && !bus.ovf_clr);
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q    <= W_EMPTY;
      shadow_q   <= '0;
      w_active_q <= '0;
      data_q     <= '0;
      psum_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      w_active_q <= w_active_d;
      data_q     <= data_d;
      psum_q     <= psum_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  assign bus.right_data  = data_q;
  assign bus.right_valid = valid_q;
  assign bus.psum_out    = psum_q;
  assign bus.psum_valid  = valid_q;
  assign bus.w_down      = shadow_q;
  assign bus.shadow_full = (state_q == W_FULL);
  assign bus.ovf         = ovf_q;
endmodule

// File: tb/tb_pipelined_pe.sv
// tb_pipelined_pe: directed and random checks of pipelined_pe against an arithmetic reference model
module tb_pipelined_pe;
  localparam int DW = 8;
  localparam int PW = 20;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;
  pipelined_pe_if #(.DATA_W(DW), .PSUM_W(PW)) bus();
  pipelined_pe #(.DATA_W(DW), .PSUM_W(PW)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));
  int n_chk = 0;
  int n_pass = 0;
  logic [DW-1:0] m_wa, m_sh, m_rd;
  logic [PW-1:0] m_psum;
  bit m_full, m_pv, m_ovf;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic drive(bit sgn, bit v, int d, int p, bit wl, int wi, bit ws, bit clr);
    bus.mode_signed = sgn;
    bus.in_valid    = v;
    bus.in_data     = DW'(d);
    bus.psum_in     = PW'(p);
    bus.w_load      = wl;
    bus.w_in        = DW'(wi);
    bus.w_swap      = ws;
    bus.ovf_clr     = clr;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic model_reset();
    m_wa = '0; m_sh = '0; m_rd = '0; m_psum = '0;
    m_full = 0; m_pv = 0; m_ovf = 0;
  endtask
  task automatic check_all(string tag);
    chk({tag, ".psum"}, 64'(bus.psum_out), 64'(m_psum));
    chk({tag, ".pv"}, 64'(bus.psum_valid), 64'(m_pv));
    chk({tag, ".rv"}, 64'(bus.right_valid), 64'(m_pv));
    chk({tag, ".rd"}, 64'(bus.right_data), 64'(m_rd));
    chk({tag, ".full"}, 64'(bus.shadow_full), 64'(m_full));
    chk({tag, ".wdown"}, 64'(bus.w_down), 64'(m_sh));
    chk({tag, ".ovf"}, 64'(bus.ovf), 64'(m_ovf));
  endtask
  // Reference: exact integer MAC, then clamp or wrap to the psum range.
  task automatic step(string tag);
    longint a, w, p, lo, hi, exact, r;
    bit ev;
    ev = 0;
    if (bus.in_valid) begin
      a  = bus.mode_signed ? longint'($signed(bus.in_data)) : longint'(bus.in_data);
      w  = bus.mode_signed ? longint'($signed(m_wa)) : longint'(m_wa);
      p  = bus.mode_signed ? longint'($signed(bus.psum_in)) : longint'(bus.psum_in);
      lo = bus.mode_signed ? -(64'sd1 <<< (PW - 1)) : 0;
      hi = bus.mode_signed ? (64'sd1 <<< (PW - 1)) - 1 : (64'sd1 <<< PW) - 1;
      exact = a * w + p;
      ev = (exact < lo) || (exact > hi);
`ifdef PE_SAT_EN
      r = exact < lo ? lo : exact > hi ? hi : exact;
`else
      r = exact;
`endif
      m_psum = PW'(r);
      m_rd   = bus.in_data;
    end
    m_pv  = bus.in_valid;
    m_ovf = ev || (m_ovf && !bus.ovf_clr);
    if (m_full && bus.w_swap) m_wa = m_sh;
    if (bus.w_load) begin
      m_sh = bus.w_in;
      m_full = 1;
    end else if (m_full && bus.w_swap) m_full = 0;
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask
  task automatic set_weight(int w);
    drive(0, 0, 0, 0, 1, w, 0, 0); step("ld");
    drive(0, 0, 0, 0, 0, 0, 1, 0); step("sw");
  endtask
  initial begin
    model_reset();
    idle();
    #12;
    check_all("reset");
    RST = 1'b1;
    @(posedge CLK); #1;
    // basic MAC
    set_weight(3);
    drive(0, 1, 5, 10, 0, 0, 0, 0); step("t1");
    chk("t1.const_psum", 64'(bus.psum_out), 64'd25);
    chk("t1.const_rd", 64'(bus.right_data), 64'd5);
    // signed vs unsigned
    set_weight(8'hFE);
    drive(1, 1, 7, 4, 0, 0, 0, 0); step("t2s");
    chk("t2.signed", 64'(bus.psum_out), 64'h0FFFF6);
    drive(0, 1, 7, 4, 0, 0, 0, 0); step("t2u");
    chk("t2.unsigned", 64'(bus.psum_out), 64'd1782);
    // double buffer
    set_weight(3);
    drive(0, 1, 1, 0, 1, 4, 0, 0); step("t3a");
    chk("t3.r0", 64'(bus.psum_out), 64'd3);
    drive(0, 1, 2, 0, 0, 0, 1, 0); step("t3b");
    chk("t3.r1", 64'(bus.psum_out), 64'd6);
    drive(0, 1, 2, 0, 0, 0, 0, 0); step("t3c");
    chk("t3.r2", 64'(bus.psum_out), 64'd8);
    drive(0, 1, 2, 0, 0, 0, 1, 0); step("t3d");
    drive(0, 1, 2, 0, 0, 0, 0, 0); step("t3e");
    chk("t3.empty_swap", 64'(bus.psum_out), 64'd8);
    // overflow / saturation, clear, and set beating clear
    set_weight(1);
    drive(0, 1, 1, 'hFFFFF, 0, 0, 0, 0); step("t4a");
`ifdef PE_SAT_EN
    chk("t4.sat", 64'(bus.psum_out), 64'hFFFFF);
`else
    chk("t4.wrap", 64'(bus.psum_out), 64'h0);
`endif
    chk("t4.ovf", 64'(bus.ovf), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 1); step("t4b");
    chk("t4.clr", 64'(bus.ovf), 64'd0);
    drive(0, 1, 1, 'hFFFFF, 0, 0, 0, 1); step("t4c");
    drive(1, 1, 1, 'h7FFFF, 0, 0, 0, 0); step("t4d");
    // async reset mid-stream
    drive(0, 1, 9, 5, 1, 7, 0, 0); step("t5a");
    drive(0, 1, 9, 5, 0, 0, 0, 0);
    #2 RST = 1'b0;
    #1;
    model_reset();
    check_all("t5.rst");
    idle();
    #2 RST = 1'b1;
    @(posedge CLK); #1;
    drive(0, 1, 9, 7, 0, 0, 0, 0); step("t5b");
    chk("t5.w_zero", 64'(bus.psum_out), 64'd7);
    // valid gaps
    set_weight(2);
    drive(0, 1, 3, 1, 0, 0, 0, 0); step("t6a");
    drive(0, 0, 4, 9, 0, 0, 0, 0); step("t6b");
    chk("t6.hold", 64'(bus.psum_out), 64'd7);
    drive(0, 1, 4, 9, 0, 0, 0, 0); step("t6c");
    // random
    for (int i = 0; i < 400; i++) begin
      drive($urandom % 2, ($urandom % 4) != 0, $urandom, $urandom, ($urandom % 3) == 0,
            $urandom, ($urandom % 3) == 0, ($urandom % 8) == 0);
      if (($urandom % 16) == 0) bus.psum_in = PW'('hFFFFF - ($urandom % 4));
      step("rnd");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
